// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types and lane constants for the PE matrix feeders
package npu_pkg;

  localparam int NPU_LANES = 4;
  localparam int SKEW_MAX  = NPU_LANES - 1;

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_window.sv
// rtl/skew_window.sv - per-lane diagonal window: buffer row select, data and enable flags
module skew_window
  import npu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 4,
  parameter int IW    = 2,
  parameter int IDX   = 0
) (
  input  logic [CW-1:0] s,
  output logic [IW-1:0] row_sel,
  output logic          row_valid,
  output logic          col_en
);

  localparam logic [CW:0]   LO      = (CW+1)'(IDX);
  localparam logic [CW:0]   HI_DATA = (CW+1)'(IDX + DEPTH);
  localparam logic [CW:0]   HI_EN   = (CW+1)'(IDX + DEPTH + SKEW_MAX - 1);
  localparam logic [IW-1:0] IDX_W   = IW'(IDX);

  logic [CW:0] s_ext;

  // row_sel is only meaningful while row_valid is set, so modular subtraction is enough
  always_comb begin
    s_ext     = {1'b0, s};
    row_sel   = s[IW-1:0] - IDX_W;
    row_valid = (s_ext >= LO) && (s_ext < HI_DATA);
    col_en    = (s_ext >= LO) && (s_ext <= HI_EN);
  end

endmodule

// File: rtl/pe_skew_feeder.sv
// rtl/pe_skew_feeder.sv - tile buffer replayed as a skewed wavefront into the PE matrix
module pe_skew_feeder
  import npu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int DRAIN = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic signed [NPU_LANES-1:0][WIDTH-1:0] wr_data,
  input  logic                                  start,
  output logic signed [NPU_LANES-1:0][WIDTH-1:0] out_left,
  output logic [NPU_LANES-1:0]                  col_enable,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CW   = $clog2(DEPTH + DRAIN + 7);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROWS = 1 << IW;

  localparam logic [CW-1:0] LAST_WR = CW'(DEPTH - 1);
  localparam logic [CW-1:0] S_END   = CW'(DEPTH + 2*SKEW_MAX - 1);
  localparam logic [CW-1:0] D_END   = CW'(DEPTH + 2*SKEW_MAX - 1 + DRAIN);

  typedef logic signed [NPU_LANES-1:0][WIDTH-1:0] vec_t;

  feeder_state_t state_q, state_d;
  logic [CW-1:0] s_q, s_d, wr_cnt_q, wr_cnt_d;
  vec_t          mem_q [ROWS];
  vec_t          mem_d [ROWS];
  vec_t          out_left_q, out_left_d;
  logic [NPU_LANES-1:0] col_enable_q, col_enable_d;
  logic          busy_q, busy_d, done_q, done_d, wr_ready_q, wr_ready_d;

  logic [IW-1:0]        row_sel [NPU_LANES];
  logic [NPU_LANES-1:0] row_valid, col_en;

  // one counter s runs through STREAM and continues through DRAIN
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    wr_cnt_d = wr_cnt_q;
    mem_d    = mem_q;
    case (state_q)
      LOAD: begin
        if (wr_valid && wr_ready_q) begin
          mem_d[wr_cnt_q[IW-1:0]] = wr_data;
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d = '0;
            state_d  = FULL;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_d = STREAM;
          s_d     = '0;
        end
      end
      STREAM: begin
        if (s_q == S_END && DRAIN == 0) begin
          state_d = LOAD;
          s_d     = '0;
        end else begin
          if (s_q == S_END) state_d = npu_pkg::DRAIN;
          s_d = s_q + 1'b1;
        end
      end
      default: begin
        if (s_q == D_END) begin
          state_d = LOAD;
          s_d     = '0;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
    endcase
  end

  for (genvar i = 0; i < NPU_LANES; i++) begin : g_win
    skew_window #(.DEPTH(DEPTH), .CW(CW), .IW(IW), .IDX(i)) u_win (
      .s         (s_d),
      .row_sel   (row_sel[i]),
      .row_valid (row_valid[i]),
      .col_en    (col_en[i])
    );
  end

  // outputs are derived from the next state so they line up with it once registered
  always_comb begin
    out_left_d   = '0;
    col_enable_d = '0;
    for (int i = 0; i < NPU_LANES; i++) begin
      if (state_d == STREAM) begin
        if (row_valid[i]) out_left_d[i] = mem_q[row_sel[i]][i];
        col_enable_d[i] = col_en[i];
      end
    end
    done_d     = (s_d == D_END) &&
                 ((state_d == npu_pkg::DRAIN) || (state_d == STREAM && DRAIN == 0));
    busy_d     = (state_d == STREAM) || (state_d == npu_pkg::DRAIN);
    wr_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      s_q          <= '0;
      wr_cnt_q     <= '0;
      out_left_q   <= '0;
      col_enable_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      wr_cnt_q     <= wr_cnt_d;
      out_left_q   <= out_left_d;
      col_enable_q <= col_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_left   = out_left_q;
  assign col_enable = col_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_ready   = wr_ready_q;

endmodule
